cnt_wnd_pipe: RTL and testbench

Pipelined, flow-controlled successor to the combinational window counter. It counts bits equal to a selected polarity inside a circular window [wnd_start, wnd_start+wnd_len) of a bitmap, with wrap-around at VECT_WIDTH. The result width can represent a full-window count. The block sits between bitmap-state readers (ack/loss bitmaps) and the transport-state update logic. Its fixed three-cycle latency lets wide bitmaps close timing.

---
 rtl/cnt_wnd_pipe_pkg.sv | 28 ++
 rtl/cnt_set.sv | 19 +
 rtl/cnt_wnd_pipe_stage.sv | 45 ++++
 rtl/cnt_wnd_pipe.sv | 96 +++++++++
 tb/tb_cnt_wnd_pipe.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/cnt_wnd_pipe_pkg.sv
// rtl/cnt_wnd_pipe_pkg.sv - shared constants and sizing helpers for the pipelined window counter
package cnt_wnd_pipe_pkg;

   localparam int CNT_WND_LATENCY     = 3;
   localparam int CNT_WND_VECT_WIDTH  = 128;
   localparam int CNT_WND_BLOCK_WIDTH = 4;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   function automatic int num_blocks(input int vect_width, input int block_width);
      return vect_width / block_width;
   endfunction

   function automatic int block_cnt_width(input int block_width);
      return clog2(block_width) + 1;
   endfunction

   localparam int NUM_BLOCKS      = num_blocks(CNT_WND_VECT_WIDTH, CNT_WND_BLOCK_WIDTH);
   localparam int BLOCK_CNT_WIDTH = block_cnt_width(CNT_WND_BLOCK_WIDTH);

endpackage

// File: rtl/cnt_set.sv
// rtl/cnt_set.sv - combinational population count of a bit vector
module cnt_set
   import cnt_wnd_pipe_pkg::*;
#(
   parameter int VECT_WIDTH = 8,
   parameter int CNT_WIDTH  = clog2(VECT_WIDTH) + 1
) (
   input  logic [VECT_WIDTH-1:0] vect_in,
   output logic [CNT_WIDTH-1:0]  cnt_out
);

   always_comb begin
      cnt_out = '0;
      for (int i = 0; i < VECT_WIDTH; i++) begin
         cnt_out = cnt_out + CNT_WIDTH'(vect_in[i]);
      end
   end

endmodule

// File: rtl/cnt_wnd_pipe_stage.sv
// rtl/cnt_wnd_pipe_stage.sv - elastic valid/ready register slice, ready passes straight through
module cnt_wnd_pipe_stage #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data
);

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  load;

   assign in_ready  = !valid_q | out_ready;
   assign out_valid = valid_q;
   assign out_data  = data_q;

   always_comb begin
      load    = in_valid & in_ready;
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = in_data;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/cnt_wnd_pipe.sv
// rtl/cnt_wnd_pipe.sv - three-stage flow-controlled count of matching bits in a circular window
module cnt_wnd_pipe
   import cnt_wnd_pipe_pkg::*;
#(
   parameter int VECT_WIDTH     = CNT_WND_VECT_WIDTH,
   parameter int VECT_IND_WIDTH = 7,
   parameter int BLOCK_WIDTH    = CNT_WND_BLOCK_WIDTH,
   parameter int CNT_WIDTH      = VECT_IND_WIDTH + 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [VECT_WIDTH-1:0]     vect_in,
   input  logic [VECT_IND_WIDTH-1:0] wnd_start_in,
   input  logic [VECT_IND_WIDTH:0]   wnd_len_in,
   input  logic                      select_set_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CNT_WIDTH-1:0]      cnt_out
);

   localparam int NB  = num_blocks(VECT_WIDTH, BLOCK_WIDTH);
   localparam int BCW = block_cnt_width(BLOCK_WIDTH);
   localparam int LW  = VECT_IND_WIDTH + 1;

   logic [LW-1:0]             len_clamp;
   logic [VECT_IND_WIDTH-1:0] idx;
   logic [VECT_WIDTH-1:0]     rot, mask, match_d, s1_match;
   logic [NB*BCW-1:0]         part_d, s2_part;
   logic [CNT_WIDTH-1:0]      sum_d;
   logic                      s1_valid, s2_valid;
   logic                      s2_ready, s3_ready;

   // Index arithmetic is VECT_IND_WIDTH bits wide, so the window wraps for free.
   always_comb begin
      len_clamp = (wnd_len_in > LW'(VECT_WIDTH)) ? LW'(VECT_WIDTH) : wnd_len_in;
      idx       = '0;
      rot       = '0;
      mask      = '0;
      for (int i = 0; i < VECT_WIDTH; i++) begin
         idx     = VECT_IND_WIDTH'(i) + wnd_start_in;
         rot[i]  = vect_in[idx];
         mask[i] = (LW'(i) < len_clamp);
      end
      match_d = ~(rot ^ {VECT_WIDTH{select_set_in}}) & mask;
   end

   cnt_wnd_pipe_stage #(.DATA_WIDTH(VECT_WIDTH)) u_s1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (match_d),
      .out_valid (s1_valid),
      .out_ready (s2_ready),
      .out_data  (s1_match)
   );

   for (genvar b = 0; b < NB; b++) begin : g_blk
      cnt_set #(.VECT_WIDTH(BLOCK_WIDTH), .CNT_WIDTH(BCW)) u_cnt (
         .vect_in (s1_match[b*BLOCK_WIDTH +: BLOCK_WIDTH]),
         .cnt_out (part_d[b*BCW +: BCW])
      );
   end

   cnt_wnd_pipe_stage #(.DATA_WIDTH(NB*BCW)) u_s2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s1_valid),
      .in_ready  (s2_ready),
      .in_data   (part_d),
      .out_valid (s2_valid),
      .out_ready (s3_ready),
      .out_data  (s2_part)
   );

   always_comb begin
      sum_d = '0;
      for (int b = 0; b < NB; b++) begin
         sum_d = sum_d + CNT_WIDTH'(s2_part[b*BCW +: BCW]);
      end
   end

   cnt_wnd_pipe_stage #(.DATA_WIDTH(CNT_WIDTH)) u_s3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s2_valid),
      .in_ready  (s3_ready),
      .in_data   (sum_d),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (cnt_out)
   );

endmodule

// File: tb/tb_cnt_wnd_pipe.sv
// tb/tb_cnt_wnd_pipe.sv - directed and streaming checks of cnt_wnd_pipe at 16-bit width
module tb_cnt_wnd_pipe;
   import cnt_wnd_pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] vect_in = '0;
   logic [3:0]  wnd_start_in = '0;
   logic [4:0]  wnd_len_in = '0;
   logic        select_set_in = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [4:0]  cnt_out;

   int n_checks = 0;
   int n_errors = 0;
   int stalls = 0;
   int exp_q[$];
   int got_q[$];
   bit done;
   logic [15:0] rv;
   int rs, rl;
   logic rsel;

   cnt_wnd_pipe #(.VECT_WIDTH(16), .VECT_IND_WIDTH(4), .BLOCK_WIDTH(4), .CNT_WIDTH(5)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .vect_in       (vect_in),
      .wnd_start_in  (wnd_start_in),
      .wnd_len_in    (wnd_len_in),
      .select_set_in (select_set_in),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .cnt_out       (cnt_out)
   );

   always #5 clk = ~clk;

   // An output handshake seen at the falling edge completes on the next rising edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) got_q.push_back(int'(cnt_out));
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_cnt(input logic [15:0] v, input int s, input int l, input logic sel);
      int lc;
      int c;
      lc = (l > 16) ? 16 : l;
      c = 0;
      for (int i = 0; i < lc; i++) begin
         if (v[(s + i) % 16] == sel) c++;
      end
      return c;
   endfunction

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [15:0] v, input int s, input int l, input logic sel, input int e);
      int n;
      vect_in       = v;
      wnd_start_in  = 4'(s);
      wnd_len_in    = 5'(l);
      select_set_in = sel;
      in_valid      = 1'b1;
      exp_q.push_back(e);
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         stalls++;
         n++;
         @(negedge clk);
      end
      if (!in_ready) check("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain_check(input string tag);
      int n;
      n = 0;
      while (got_q.size() < exp_q.size() && n < 1000) begin
         n++;
         @(negedge clk);
      end
      repeat (4) @(negedge clk);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      while (exp_q.size() > 0 && got_q.size() > 0) check(tag, got_q.pop_front(), exp_q.pop_front());
      exp_q.delete();
      got_q.delete();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_cnt_out", cnt_out, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // Single request: latency and value.
      send(16'h00FF, 0, 16, 1'b1, 8);
      for (int k = 1; k <= CNT_WND_LATENCY; k++) begin
         @(negedge clk);
         check($sformatf("latency_edge%0d", k), out_valid, (k == CNT_WND_LATENCY) ? 1 : 0);
      end
      check("lat_cnt", cnt_out, 8);
      drain_check("basic");

      send(16'hF00F, 12, 8, 1'b1, 8);
      send(16'hF00F, 12, 8, 1'b0, 0);
      send(16'h0000, 5, 16, 1'b0, 16);
      send(16'hFFFF, 3, 0, 1'b1, 0);
      send(16'h1234, 7, 20, 1'b1, 5);
      send(16'h8001, 15, 2, 1'b1, 2);
      send(16'hAAAA, 1, 3, 1'b0, 1);
      send(16'h00F0, 2, 5, 1'b1, 3);
      drain_check("directed");

      // Backpressure: five requests against a stalled consumer.
      out_ready = 1'b0;
      fork
         begin
            send(16'h0001, 0, 16, 1'b1, 1);
            send(16'h0003, 0, 16, 1'b1, 2);
            send(16'h0007, 0, 16, 1'b1, 3);
            send(16'h000F, 0, 16, 1'b1, 4);
            send(16'h001F, 0, 16, 1'b1, 5);
         end
         begin
            repeat (5) @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_hold_a", cnt_out, 1);
            @(negedge clk);
            check("bp_hold_b", cnt_out, 1);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain_check("bp");

      // Reset with requests in flight.
      out_ready = 1'b0;
      send(16'hFFFF, 0, 16, 1'b1, 16);
      send(16'h0F0F, 0, 16, 1'b1, 8);
      @(posedge clk);
      #1;
      check("mid_pre_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("mid_async_valid", out_valid, 0);
      check("mid_async_cnt", cnt_out, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_in_ready", in_ready, 1);
      out_ready = 1'b1;
      repeat (10) @(negedge clk);
      check("mid_stale", got_q.size(), 0);
      check("mid_out_valid", out_valid, 0);
      @(posedge clk);
      #1;
      send(16'h0F0F, 4, 8, 1'b1, 4);
      drain_check("post_rst");

      // Streaming with random consumer stalls.
      done = 1'b0;
      fork
         begin
            for (int k = 0; k < 300; k++) begin
               rv   = 16'($urandom);
               rs   = $urandom_range(0, 15);
               rl   = $urandom_range(0, 20);
               rsel = 1'($urandom_range(0, 1));
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               send(rv, rs, rl, rsel, ref_cnt(rv, rs, rl, rsel));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      drain_check("stream");

      // Full-rate burst: no request may wait.
      stalls = 0;
      for (int k = 0; k < 20; k++) begin
         rv   = 16'($urandom);
         rs   = $urandom_range(0, 15);
         rl   = $urandom_range(0, 20);
         rsel = 1'($urandom_range(0, 1));
         send(rv, rs, rl, rsel, ref_cnt(rv, rs, rl, rsel));
      end
      check("thru_stalls", stalls, 0);
      drain_check("thru");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
